// File: rtl/param_stack_unit.sv
// param_stack_unit: parametrised LIFO operand stack.
//   WIDTH-bit words, DEPTH entries, occupancy count, full/empty, sticky
//   overflow/underflow, push+pop replace-top and registered read data.
//   Optional feature macro STACK_POP2_EN adds a pop2 input and a dout_b
//   output that remove the top two entries in one cycle (for binary ALU ops).
//   No handshake: each command is a single-cycle strobe. Read data appears
//   on dout (and dout_b) the cycle after the command edge and holds until the
//   next successful read.
module param_stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             tos,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
`ifdef STACK_POP2_EN
  ,
  input  logic             pop2,
  output logic [WIDTH-1:0] dout_b
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] top_idx;
  logic [AW-1:0] push_idx;
  logic [AW-1:0] wr_idx;
  logic [CW-1:0] count_nxt;
  logic          pop2_req;
  logic          rd_top;
  logic          rd_two;
  logic          wr_en;
  logic          set_ov;
  logic          set_un;

`ifdef STACK_POP2_EN
  assign pop2_req = pop2;
`else
  assign pop2_req = 1'b0;
`endif

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign top_idx  = AW'(count - CW'(1));
  assign push_idx = AW'(count);

  // Command decode: one action per cycle, highest priority first.
  always_comb begin
    rd_top    = 1'b0;
    rd_two    = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = push_idx;
    set_ov    = 1'b0;
    set_un    = 1'b0;
    count_nxt = count;
    if (pop2_req) begin
      if (count >= CW'(2)) begin
        rd_two    = 1'b1;
        count_nxt = count - CW'(2);
      end else begin
        set_un = 1'b1;
      end
    end else if (push && pop) begin
      // Replace-top: old top goes out, din takes its slot, depth unchanged.
      if (!empty) begin
        rd_top = 1'b1;
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else begin
        set_un = 1'b1;
      end
    end else if (push) begin
      if (!full) begin
        wr_en     = 1'b1;
        count_nxt = count + CW'(1);
      end else begin
        set_ov = 1'b1;
      end
    end else if (pop) begin
      if (!empty) begin
        rd_top    = 1'b1;
        count_nxt = count - CW'(1);
      end else begin
        set_un = 1'b1;
      end
    end else if (tos) begin
      if (!empty) begin
        rd_top = 1'b1;
      end else begin
        set_un = 1'b1;
      end
    end
  end

  // Storage array; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= din;
    end
  end

  // Occupancy, read data and sticky flags; an error set beats clr_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count <= count_nxt;
      if (rd_top || rd_two) begin
        dout <= mem[top_idx];
      end
      overflow  <= set_ov | (overflow & ~clr_err);
      underflow <= set_un | (underflow & ~clr_err);
    end
  end

`ifdef STACK_POP2_EN
  logic [AW-1:0] next_idx;
  assign next_idx = AW'(count - CW'(2));

  // Second operand output, loaded only by a successful pop2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_b <= '0;
    end else if (rd_two) begin
      dout_b <= mem[next_idx];
    end
  end
`endif

endmodule

// File: tb/tb_param_stack_unit.sv
// tb_param_stack_unit: directed scenarios plus randomized commands checked
// against a queue-based LIFO model. Honours STACK_POP2_EN like the design.
module tb_param_stack_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             push;
  logic             pop;
  logic             tos;
  logic             clr_err;
  logic             pop2;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] dout_b;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  // reference model state
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_dout;
  logic [WIDTH-1:0] m_dout_b;
  logic             m_ov;
  logic             m_un;

  int total = 0;
  int bad   = 0;

  param_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .tos       (tos),
    .clr_err   (clr_err),
    .din       (din),
    .dout      (dout),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef STACK_POP2_EN
    ,
    .pop2      (pop2),
    .dout_b    (dout_b)
`endif
  );

`ifndef STACK_POP2_EN
  assign dout_b = '0;
`endif

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_dout   = '0;
    m_dout_b = '0;
    m_ov     = 1'b0;
    m_un     = 1'b0;
  endtask

  // LIFO rules applied to a queue whose back is the top of stack.
  task automatic model_step(input logic p, input logic pp, input logic t,
                            input logic c, input logic p2, input logic [WIDTH-1:0] d);
    if (c) begin
      m_ov = 1'b0;
      m_un = 1'b0;
    end
    if (p2) begin
      if (exp_q.size() >= 2) begin
        m_dout   = exp_q.pop_back();
        m_dout_b = exp_q.pop_back();
      end else m_un = 1'b1;
    end else if (p && pp) begin
      if (exp_q.size() >= 1) begin
        m_dout = exp_q[exp_q.size() - 1];
        exp_q[exp_q.size() - 1] = d;
      end else m_un = 1'b1;
    end else if (p) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else m_ov = 1'b1;
    end else if (pp) begin
      if (exp_q.size() >= 1) m_dout = exp_q.pop_back();
      else m_un = 1'b1;
    end else if (t) begin
      if (exp_q.size() >= 1) m_dout = exp_q[exp_q.size() - 1];
      else m_un = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(count), 32'(exp_q.size()));
    check({tag, ".full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
    check({tag, ".dout"}, 32'(dout), 32'(m_dout));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ov));
    check({tag, ".unf"}, 32'(underflow), 32'(m_un));
`ifdef STACK_POP2_EN
    check({tag, ".dout_b"}, 32'(dout_b), 32'(m_dout_b));
`endif
  endtask

  // driver: apply one command for one clock, update model, sample at edge+1
  task automatic step(input logic p, input logic pp, input logic t, input logic c,
                      input logic p2, input logic [WIDTH-1:0] d, input string tag);
    push    = p;
    pop     = pp;
    tos     = t;
    clr_err = c;
    pop2    = p2;
    din     = d;
    @(posedge clk);
    model_step(p, pp, t, c, p2, d);
    #1;
    check_all(tag);
    push    = 1'b0;
    pop     = 1'b0;
    tos     = 1'b0;
    clr_err = 1'b0;
    pop2    = 1'b0;
  endtask

  task automatic do_push(input logic [WIDTH-1:0] d, input string tag);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, d, tag);
  endtask

  task automatic do_pop(input string tag);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, tag);
  endtask

  initial begin
    logic          rp, rpp, rt, rc, rp2;
    int            r;
    rst     = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    tos     = 1'b0;
    clr_err = 1'b0;
    pop2    = 1'b0;
    din     = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // empty-stack underflow, dout holds, clear and set-wins
    do_pop("t4_pop");
    check("t4_unf_const", 32'(underflow), 32'd1);
    check("t4_dout_const", 32'(dout), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, "t4_tos");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, "t4_clr");
    check("t4_clr_const", 32'(underflow), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0, "t4_clr_pop");
    check("t4_setwins_const", 32'(underflow), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, "t4_clr2");

    // LIFO order
    do_push(8'h11, "t2_push");
    do_push(8'h22, "t2_push");
    do_push(8'h33, "t2_push");
    do_pop("t2_pop");
    check("t2_pop1_const", 32'(dout), 32'h33);
    do_pop("t2_pop");
    check("t2_pop2_const", 32'(dout), 32'h22);
    do_pop("t2_pop");
    check("t2_pop3_const", 32'(dout), 32'h11);
    check("t2_empty_const", 32'(empty), 32'd1);

    // fill, overflow, drained order
    for (int i = 1; i <= 5; i++) begin
      do_push(WIDTH'(i), "t3_push");
      if (i == 4) check("t3_full_const", 32'(full), 32'd1);
    end
    check("t3_ovf_const", 32'(overflow), 32'd1);
    check("t3_count_const", 32'(count), 32'd4);
    for (int i = 4; i >= 1; i--) begin
      do_pop("t3_pop");
      check("t3_pop_const", 32'(dout), 32'(i));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, "t3_clr");

    // replace-top
    do_push(8'h0A, "t5_push");
    do_push(8'h0B, "t5_push");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC0, "t5_rep");
    check("t5_rep_dout_const", 32'(dout), 32'h0B);
    check("t5_rep_count_const", 32'(count), 32'd2);
    do_pop("t5_pop");
    check("t5_pop_const", 32'(dout), 32'hC0);
    do_pop("t5_pop");

`ifdef STACK_POP2_EN
    // dual pop
    do_push(8'h05, "t6_push");
    do_push(8'h07, "t6_push");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, "t6_pop2");
    check("t6_dout_const", 32'(dout), 32'h07);
    check("t6_doutb_const", 32'(dout_b), 32'h05);
    check("t6_count_const", 32'(count), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, "t6_pop2_unf");
    check("t6_unf_const", 32'(underflow), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, "t6_clr");
`endif

    // asynchronous reset mid-run with three entries
    do_push(8'h41, "t1_push");
    do_push(8'h42, "t1_push");
    do_push(8'h43, "t1_push");
    do_pop("t1_pop");
    do_push(8'h44, "t1_push");
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("t1_async");
    check("t1_empty_const", 32'(empty), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // randomized commands
    for (int n = 0; n < 400; n++) begin
      r   = int'($urandom_range(0, 99));
      rp  = (r < 45);
      rpp = (r >= 30 && r < 75);
      rt  = ($urandom_range(0, 3) == 0);
      rc  = ($urandom_range(0, 9) == 0);
      rp2 = 1'b0;
`ifdef STACK_POP2_EN
      rp2 = ($urandom_range(0, 7) == 0);
`endif
      step(rp, rpp, rt, rc, rp2, WIDTH'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
